// File: rtl/microcode_sequencer_if.sv
// Microcode EPROM bus plus microword valid/ack handshake toward the control decoder.
// master = sequencer (initiator), slave = EPROM model / decoder side.
interface microcode_sequencer_if;
    logic        _mc_cs;
    logic        _mc_oe;
    logic [7:0]  mc_addr;
    logic [63:0] mc_data;
    logic [63:0] uw;
    logic        uw_valid;
    logic        uw_ack;

    modport master (
        output _mc_cs,
        output _mc_oe,
        output mc_addr,
        output uw,
        output uw_valid,
        input  mc_data,
        input  uw_ack
    );

    modport slave (
        input  _mc_cs,
        input  _mc_oe,
        input  mc_addr,
        input  uw,
        input  uw_valid,
        output mc_data,
        output uw_ack
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer / EPROM fetcher: start -> uw_valid in ACCESS_CYCLES+3 clocks; uw held until uw_ack.
// Define MC_PARITY_EN to add an odd-parity check on each fetched word with a sticky ERROR state.
module microcode_sequencer #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [7:0]  ENTRY_BASE    = 8'h00
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   opcode,
    input  logic                         cond,
    microcode_sequencer_if.master        mc,
    output logic                         busy,
    output logic [7:0]                   upc,
    output logic                         parity_err
);

    localparam logic [3:0] WAIT_LAST = 4'(ACCESS_CYCLES - 1);

`ifdef MC_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ENABLE,
        S_LATCH,
        S_HOLD,
        S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ENABLE,
        S_LATCH,
        S_HOLD
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  upc_q, upc_d;
    logic [63:0] uw_q, uw_d;
    logic        uw_valid_q, uw_valid_d;
    logic        cs_n_q, cs_n_d;
    logic        oe_n_q, oe_n_d;

    logic [7:0]  uw_next;
    logic        uw_seq;
    logic        uw_cond_br;
    logic        uw_end;

    assign uw_next    = uw_q[7:0];
    assign uw_seq     = uw_q[8];
    assign uw_cond_br = uw_q[9];
    assign uw_end     = uw_q[10];

`ifdef MC_PARITY_EN
    logic perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        upc_d   = upc_q;
        uw_d    = uw_q;
`ifdef MC_PARITY_EN
        perr_d  = perr_q;
`endif
        // Strobes lag the state by one clock: address is stable a cycle before
        // _mc_cs falls, and _mc_oe is low for exactly ACCESS_CYCLES clocks ending in LATCH.
        cs_n_d  = !((state_q == S_SELECT) || (state_q == S_ENABLE));
        oe_n_d  = !(state_q == S_ENABLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    upc_d   = opcode + ENTRY_BASE;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                wait_d  = 4'd0;
                state_d = S_ENABLE;
            end
            S_ENABLE: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = S_LATCH;
                end else begin
                    wait_d  = wait_q + 4'd1;
                end
            end
            S_LATCH: begin
                uw_d    = mc.mc_data;
                state_d = S_HOLD;
`ifdef MC_PARITY_EN
                if (!(^mc.mc_data)) begin
                    perr_d  = 1'b1;
                    state_d = S_ERROR;
                end
`endif
            end
            S_HOLD: begin
                if (mc.uw_ack) begin
                    if (uw_end) begin
                        state_d = S_IDLE;
                    end else begin
                        if (uw_cond_br) begin
                            upc_d = cond ? uw_next : (upc_q + 8'd1);
                        end else if (uw_seq) begin
                            upc_d = upc_q + 8'd1;
                        end else begin
                            upc_d = uw_next;
                        end
                        state_d = S_SELECT;
                    end
                end
            end
`ifdef MC_PARITY_EN
            S_ERROR: begin
                state_d = S_ERROR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        uw_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            upc_q      <= 8'h00;
            uw_q       <= 64'h0;
            uw_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            upc_q      <= upc_d;
            uw_q       <= uw_d;
            uw_valid_q <= uw_valid_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

`ifdef MC_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign mc._mc_cs   = cs_n_q;
    assign mc._mc_oe   = oe_n_q;
    assign mc.mc_addr  = upc_q;
    assign mc.uw       = uw_q;
    assign mc.uw_valid = uw_valid_q;
    assign upc         = upc_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Initiator side of the microcode EPROM interface.
- Sequences the 8-bit micro-PC and drives the active-low chip-select, output-enable and address lines.
- Waits out the EPROM access time, then latches each 64-bit microword into a holding register.
- Presents the microword to the control decoder with a valid/ack handshake and computes the next micro-address from the word's sequencing field.

Parameters:
- ACCESS_CYCLES, 2: clocks _mc_oe is held low before data is sampled; legal range 1-15.
- ENTRY_BASE, 8'h00: added (mod 256) to the opcode to form the entry micro-address.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin the microsequence for opcode.
- opcode  input  8  instruction opcode, sampled when start is accepted.
- cond  input  1  branch condition from datapath, sampled in HOLD on the ack cycle.
- _mc_cs  output  1  EPROM chip select, active low.
- _mc_oe  output  1  EPROM output enable, active low.
- mc_addr  output  8  EPROM address (= upc).
- mc_data  input  64  EPROM data bus; Z when _mc_oe high.
- uw  output  64  latched microword.
- uw_valid  output  1  uw holds a valid microword.
- uw_ack  input  1  consumer has taken uw.
- busy  output  1  high in every state except IDLE.
- upc  output  8  current micro-PC.
- parity_err  output  1  sticky parity error; present only with the optional feature.

Behaviour:
- Reset values:
  - _mc_cs=1, _mc_oe=1, mc_addr=0, upc=0.
  - uw=0, uw_valid=0, busy=0, parity_err=0.
  - State IDLE; wait counter 0.
- Reset mid-operation: all outputs return to reset values at that edge and the in-flight word is discarded.
- Microword sequencing field:
  - [7:0] NEXT, [8] SEQ, [9] COND_BR, [10] END.
  - [62:11] are opaque to this block.
  - [63] is opaque, or parity when the optional feature is enabled.
- FSM (registered outputs):
  - IDLE: _mc_cs=1, _mc_oe=1. On start: upc <= opcode + ENTRY_BASE (8-bit wrap), go to SELECT.
  - SELECT (1 cycle): _mc_cs=0, _mc_oe=1, mc_addr=upc. Go to ENABLE.
  - ENABLE: _mc_cs=0, _mc_oe=0. Stay ACCESS_CYCLES cycles, counted by the wait counter. Then go to LATCH.
  - LATCH (1 cycle): uw <= mc_data; _mc_cs=1, _mc_oe=1 at the next edge. Go to HOLD.
  - HOLD: uw_valid=1. Wait for uw_ack; uw is stable while valid. On the ack cycle, compute next address by priority:
    - END=1 -> IDLE, with uw_valid=0 the next cycle.
    - else COND_BR=1 -> upc <= cond ? NEXT : upc+1.
    - else SEQ=1 -> upc <= upc+1.
    - else -> upc <= NEXT.
    - In all non-END cases go to SELECT with uw_valid=0.
- Timing:
  - mc_data is sampled only in LATCH, never while _mc_oe is high.
  - Latency: start to uw_valid = ACCESS_CYCLES+3 clocks (SELECT, ENABLE×N, LATCH, then valid).
- Boundary conditions:
  - upc+1 at 8'hFF wraps to 8'h00.
  - start while busy is ignored.
  - uw_ack while uw_valid=0 is ignored.
  - uw_ack asserted in the same cycle uw_valid first rises is accepted.
  - start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: MC_PARITY_EN.
- Defined:
  - In LATCH, compute odd parity over mc_data[63:0].
  - On mismatch (even count), set parity_err; it is sticky until reset.
  - Go to state ERROR instead of HOLD: uw_valid=0, _mc_cs=1, _mc_oe=1, busy=1. ERROR is left only by reset.
- Undefined:
  - No check is made and no ERROR state exists.
  - parity_err is tied 0; bit 63 passes through in uw.

Test Plan:
- Reset, then start with opcode=8'h10, ACCESS_CYCLES=2, word at 0x10 having SEQ=1 -> mc_addr=0x10 with _mc_cs low; _mc_oe low for exactly 2 clocks; uw_valid at clock 5 with uw matching ROM[0x10]; after ack, next fetch at 0x11.
- Word at 0x20: COND_BR=1, NEXT=0x40. Run once with cond=1 at ack -> next addr 0x40. Run again with cond=0 -> next addr 0x21.
- Word at 0xFF with SEQ=1 -> next fetch at 0x00 (wrap).
- END=1 word, ack held off 5 cycles -> uw stable and uw_valid high for the whole hold; returns to IDLE one cycle after ack with busy=0 and _mc_cs=_mc_oe=1.
- Reset asserted during ENABLE -> next edge _mc_cs=_mc_oe=1, uw_valid=0, upc=0; a second start during busy is ignored (upc unchanged).
- MC_PARITY_EN defined, ROM word with even bit count -> parity_err=1, uw_valid stays 0, busy stays 1 until reset clears it.
